// File: rtl/dma_channel_chunk_scheduler.sv
// Holds per-channel DMA descriptors and turns each arbiter grant into one command of at most MAX_CHUNK bytes.
// Latency: cmd_valid one cycle after grant, arb_ack one cycle after the engine completion.
// Backpressure: the command holds stable until cmd_ready; only one command is outstanding at a time.
module dma_channel_chunk_scheduler #(
  parameter int NUM_CHANNELS = 4,
  parameter int ADDR_WIDTH   = 32,
  parameter int CNT_WIDTH    = 23,
  parameter int MAX_CHUNK    = 4096,
  localparam int CW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic [NUM_CHANNELS-1:0]            start,
  input  logic [NUM_CHANNELS*ADDR_WIDTH-1:0] desc_src,
  input  logic [NUM_CHANNELS*ADDR_WIDTH-1:0] desc_dst,
  input  logic [NUM_CHANNELS*CNT_WIDTH-1:0]  desc_bytes,
  output logic [NUM_CHANNELS-1:0]            arb_req,
  input  logic [NUM_CHANNELS-1:0]            arb_grant,
  output logic                               arb_ack,
  output logic                               cmd_valid,
  input  logic                               cmd_ready,
  output logic [CW-1:0]                      cmd_chan,
  output logic [ADDR_WIDTH-1:0]              cmd_src,
  output logic [ADDR_WIDTH-1:0]              cmd_dst,
  output logic [CNT_WIDTH-1:0]               cmd_len,
  output logic                               cmd_last,
  input  logic                               cmp_valid,
  input  logic                               cmp_error,
  output logic [NUM_CHANNELS-1:0]            chan_done,
  output logic [NUM_CHANNELS-1:0]            chan_err
);

  localparam logic [CNT_WIDTH-1:0] MAX_LEN = CNT_WIDTH'(MAX_CHUNK);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

  typedef struct packed {
    logic [CW-1:0]         chan;
    logic [ADDR_WIDTH-1:0] src;
    logic [ADDR_WIDTH-1:0] dst;
    logic [CNT_WIDTH-1:0]  len;
    logic                  last;
  } cmd_t;

  state_t state_q, state_d;
  cmd_t   cmd_q;

  logic [ADDR_WIDTH-1:0] src_q [NUM_CHANNELS];
  logic [ADDR_WIDTH-1:0] dst_q [NUM_CHANNELS];
  logic [CNT_WIDTH-1:0]  rem_q [NUM_CHANNELS];

  logic          grant_any;
  logic [CW-1:0] grant_sel;
  logic [CNT_WIDTH-1:0] sel_rem;
  logic          capture;
  logic          complete;
  logic          busy;

  always_comb begin
    grant_sel = '0;
    for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
      if (arb_grant[i]) grant_sel = CW'(i);
    end
  end

  assign grant_any = |arb_grant;
  assign sel_rem   = rem_q[grant_sel];
  assign capture   = ((state_q == IDLE) || (state_q == ACK)) && grant_any;
  assign complete  = (state_q == WAIT) && cmp_valid;
  assign busy      = (state_q == ISSUE) || (state_q == WAIT);

  always_comb begin
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      arb_req[i] = (rem_q[i] != '0);
    end
  end

  assign arb_ack   = (state_q == ACK);
  assign cmd_valid = (state_q == ISSUE);
  assign cmd_chan  = cmd_q.chan;
  assign cmd_src   = cmd_q.src;
  assign cmd_dst   = cmd_q.dst;
  assign cmd_len   = cmd_q.len;
  assign cmd_last  = cmd_q.last;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, ACK: begin
        if (grant_any) begin
          // A grant to a channel with nothing left is just acknowledged.
          state_d = (sel_rem != '0) ? ISSUE : ACK;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE:   if (cmd_ready) state_d = WAIT;
      WAIT:    if (cmp_valid) state_d = ACK;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      cmd_q     <= '0;
      chan_done <= '0;
      chan_err  <= '0;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        src_q[i] <= '0;
        dst_q[i] <= '0;
        rem_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      chan_done <= '0;
      chan_err  <= '0;

      for (int i = 0; i < NUM_CHANNELS; i++) begin
        if (start[i] && (rem_q[i] == '0) && !(busy && (cmd_q.chan == CW'(i)))) begin
          src_q[i] <= desc_src[i*ADDR_WIDTH +: ADDR_WIDTH];
          dst_q[i] <= desc_dst[i*ADDR_WIDTH +: ADDR_WIDTH];
          rem_q[i] <= desc_bytes[i*CNT_WIDTH +: CNT_WIDTH];
          if (desc_bytes[i*CNT_WIDTH +: CNT_WIDTH] == '0) chan_done[i] <= 1'b1;
        end
      end

      if (capture && (sel_rem != '0)) begin
        cmd_q.chan <= grant_sel;
        cmd_q.src  <= src_q[grant_sel];
        cmd_q.dst  <= dst_q[grant_sel];
        cmd_q.len  <= (sel_rem > MAX_LEN) ? MAX_LEN : sel_rem;
        cmd_q.last <= (sel_rem <= MAX_LEN);
      end

      // Status pulses are registered here so they land in the ACK cycle.
      if (complete) begin
        if (cmp_error) begin
          rem_q[cmd_q.chan]    <= '0;
          chan_err[cmd_q.chan] <= 1'b1;
        end else begin
          src_q[cmd_q.chan] <= src_q[cmd_q.chan] + ADDR_WIDTH'(cmd_q.len);
          dst_q[cmd_q.chan] <= dst_q[cmd_q.chan] + ADDR_WIDTH'(cmd_q.len);
          rem_q[cmd_q.chan] <= rem_q[cmd_q.chan] - cmd_q.len;
          if (cmd_q.last) chan_done[cmd_q.chan] <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/dma_channel_chunk_scheduler.md
Name: dma_channel_chunk_scheduler

Overview:
Sits directly downstream of the DMA round-robin request arbiter and feeds it its request vector. Holds per-channel transfer state (source, destination, remaining bytes). On each arbiter grant it issues one chunk command of at most MAX_CHUNK bytes to the DMA transfer engine. It waits for the engine completion, then acknowledges the arbiter, so long transfers interleave fairly across channels chunk by chunk.

Parameters:
NUM_CHANNELS, 4, number of channels; width of the request and grant vectors.
ADDR_WIDTH, 32, source/destination address width.
CNT_WIDTH, 23, byte-count width.
MAX_CHUNK, 4096, maximum bytes per issued command; power of two, at most 2^CNT_WIDTH-1.

Ports:
clock  in  1  system clock, all logic rising-edge.
reset  in  1  synchronous, active-high reset.
start  in  NUM_CHANNELS  per-channel descriptor load strobe.
desc_src  in  NUM_CHANNELS*ADDR_WIDTH  flattened source addresses; channel i occupies slice i.
desc_dst  in  NUM_CHANNELS*ADDR_WIDTH  flattened destination addresses.
desc_bytes  in  NUM_CHANNELS*CNT_WIDTH  flattened byte counts.
arb_req  out  NUM_CHANNELS  bit i high while channel i has remaining bytes greater than 0.
arb_grant  in  NUM_CHANNELS  arbiter grant; one-hot pulse.
arb_ack  out  1  one-cycle pulse that releases the arbiter.
cmd_valid  out  1  chunk command valid.
cmd_ready  in  1  engine accepts the command.
cmd_chan  out  clog2(NUM_CHANNELS) (minimum 1)  channel index.
cmd_src, cmd_dst  out  ADDR_WIDTH  chunk addresses.
cmd_len  out  CNT_WIDTH  chunk byte length, never 0.
cmd_last  out  1  this chunk completes the channel's transfer.
cmp_valid  in  1  engine completion pulse for the outstanding command.
cmp_error  in  1  completion carries an error; qualified by cmp_valid.
chan_done  out  NUM_CHANNELS  one-cycle pulse: channel finished cleanly.
chan_err  out  NUM_CHANNELS  one-cycle pulse: channel aborted on error.

Behaviour:
- Reset (synchronous, active-high) clears:
  - all remaining counts, so arb_req = 0;
  - the FSM to IDLE;
  - cmd_valid, arb_ack, chan_done and chan_err to 0;
  - command fields to 0.
  Reset mid-transfer abandons the outstanding command with no ack and no done/err pulse.
- Load: start[i] with channel i inactive (remaining = 0 and not in flight) latches src, dst and bytes.
  - arb_req[i] rises the next cycle.
  - start to an active channel is ignored.
  - Multiple simultaneous starts all load.
  - bytes = 0 produces no request; chan_done[i] pulses the next cycle instead.
- FSM states: IDLE, ISSUE, WAIT, ACK.
- IDLE:
  - A nonzero arb_grant selects the lowest set bit as channel c.
  - cmd fields are registered: len = min(rem[c], MAX_CHUNK); cmd_last = (rem[c] <= MAX_CHUNK).
  - Go to ISSUE; cmd_valid is high in the cycle after the grant.
  - If channel c has rem = 0 (grant to an idle channel), go to ACK without issuing a command.
- ISSUE:
  - cmd_valid stays high and all cmd fields hold stable until cmd_ready.
  - Handshake in cycle T: cmd_valid = 0 at T+1, state WAIT.
- WAIT:
  - On cmp_valid without error: src[c] += len, dst[c] += len (wrapping modulo 2^ADDR_WIDTH), rem[c] -= len.
  - On cmp_valid with cmp_error: rem[c] cleared to 0.
  - Either way, go to ACK.
- ACK:
  - arb_ack = 1 for exactly this cycle.
  - arb_req already reflects the updated rem, so the arbiter re-grant computed in this cycle is valid.
  - chan_done[c] pulses in this cycle if rem[c] became 0 cleanly; chan_err[c] pulses if the completion carried an error.
  - A nonzero arb_grant in the ACK cycle is captured exactly as in IDLE (go to ISSUE); otherwise go to IDLE.
- cmp_valid outside WAIT is ignored. arb_grant outside IDLE/ACK is ignored.
- Only one command is ever outstanding.

Test Plan:
- Single channel, bytes=10000, MAX_CHUNK=4096, engine ready at once, completion 3 cycles after the handshake -> three commands with len 4096, 4096, 1808; addresses step by 4096; cmd_last only on the third; three arb_ack pulses; chan_done[0] pulses in the final ACK cycle; arb_req[0] falls at the same edge.
- Channels 0 and 2 each with 8192 bytes, fed through the round-robin arbiter -> command order ch0, ch2, ch0, ch2; each re-grant is captured in the ACK cycle, so cmd_valid is high in the next cycle with no idle gap.
- cmd_ready held low for 5 cycles -> cmd_src, cmd_dst, cmd_len and cmd_chan hold stable across all 5 cycles; exactly one handshake occurs.
- cmp_error on the first chunk of a 9000-byte channel -> chan_err pulses in the ACK cycle; arb_req drops; no further commands; chan_done never pulses.
- start with bytes=0 -> chan_done pulses the next cycle; arb_req stays 0. start re-pulsed on a busy channel -> its descriptor is unchanged.
- src=0xFFFFF000, len 8192 -> second chunk cmd_src = 0x00000000 (wrap). reset asserted in WAIT -> all outputs 0 at the next edge; a cmp_valid arriving afterwards is ignored.
